// File: rtl/wormy_input_conditioner_pkg.sv
// Purpose: shared direction type and helpers for the wormy input path.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package wormy_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam dir_t DIR_RESET = DIR_RIGHT;

    // Opposite heading: flipping bit 1 maps up<->down and right<->left.
    function automatic dir_t reverse(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/wormy_input_conditioner_if.sv
// Purpose: button/tick inputs and conditioned outputs of the wormy input conditioner.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level or single-cycle strobes.
interface wormy_input_conditioner_if #(
    parameter int NUM_BTN = 4,
    parameter int QDEPTH  = 2
);
    import wormy_pkg::*;

    logic [NUM_BTN-1:0]           btn_raw;
    logic                         tick;
    logic [NUM_BTN-1:0]           btn_level;
    logic [NUM_BTN-1:0]           btn_press;
    dir_t                         dir;
    logic                         dir_changed;
    logic [$clog2(QDEPTH+1)-1:0]  q_count;
    logic                         q_overflow;

    modport master (
        output btn_raw, tick,
        input  btn_level, btn_press, dir, dir_changed, q_count, q_overflow
    );

    modport slave (
        input  btn_raw, tick,
        output btn_level, btn_press, dir, dir_changed, q_count, q_overflow
    );

endinterface

// File: rtl/wormy_debounce.sv
// Purpose: one button channel: synchroniser, stability counter, debounced level and press pulse.
// Latency: SYNC_STAGES+DB_CYCLES cycles raw->level; press coincides with the level rise.
// Backpressure: none.
module wormy_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);
    localparam int             CW   = $clog2(DB_CYCLES);
    localparam logic [CW-1:0]  CMAX = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   s;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], btn_raw};
        s       = sync_q[SYNC_STAGES-1];
        level_d = level_q;
        cnt_d   = '0;
        if (s != level_q) begin
            if (cnt_q == CMAX) level_d = s;
            else               cnt_d   = cnt_q + CW'(1);
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;

endmodule

// File: rtl/wormy_input_conditioner.sv
// Purpose: debounces NUM_BTN buttons and queues valid direction presses, committing one per tick.
// Latency: queue/dir/overflow outputs register one cycle after the press or tick that causes them.
// Backpressure: none; a press that finds the queue full (and no tick) is dropped with q_overflow.
module wormy_input_conditioner
    import wormy_pkg::*;
#(
    parameter int NUM_BTN     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 1000,
    parameter int QDEPTH      = 2,
    parameter int DIR_MODE    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    wormy_input_conditioner_if.slave   bus
);
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] press;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        wormy_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_db (
            .clk       (clk),
            .rst       (rst),
            .btn_raw   (bus.btn_raw[i]),
            .btn_level (level[i]),
            .btn_press (press[i])
        );
    end

    assign bus.btn_level = level;
    assign bus.btn_press = press;

    if (DIR_MODE != 0) begin : g_queue
        localparam int PW   = $clog2(QDEPTH);
        localparam int CNTW = $clog2(QDEPTH + 1);

        dir_t            mem_q [QDEPTH];
        dir_t            mem_d [QDEPTH];
        logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [CNTW-1:0] cnt_q, cnt_d;
        dir_t            dir_q, dir_d;
        logic            chg_q, chg_d;
        logic            ovf_q, ovf_d;
        logic            cand_vld, accept, full, push, pop;
        dir_t            cand, ref_dir;

        always_comb begin
            cand_vld = 1'b0;
            cand     = DIR_UP;
            for (int i = NUM_BTN - 1; i >= 0; i--) begin
                if (press[i]) begin
                    cand_vld = 1'b1;
                    cand     = dir_t'(i[1:0]);
                end
            end

            // Compare against where the worm will be heading once the queue drains.
            ref_dir = (cnt_q != '0) ? mem_q[wr_ptr_q - PW'(1)] : dir_q;
            accept  = cand_vld && (cand != ref_dir) && (cand != reverse(ref_dir));
            full    = (cnt_q == CNTW'(QDEPTH));
            pop     = bus.tick && (cnt_q != '0);
            push    = accept && (!full || pop);
            ovf_d   = accept && full && !pop;

            mem_d = mem_q;
            if (push) mem_d[wr_ptr_q] = cand;
            wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
            rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
            cnt_d    = cnt_q + CNTW'(push) - CNTW'(pop);
            dir_d    = pop ? mem_q[rd_ptr_q] : dir_q;
            chg_d    = pop;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < QDEPTH; i++) mem_q[i] <= DIR_UP;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                dir_q    <= DIR_RESET;
                chg_q    <= 1'b0;
                ovf_q    <= 1'b0;
            end else begin
                mem_q    <= mem_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
                dir_q    <= dir_d;
                chg_q    <= chg_d;
                ovf_q    <= ovf_d;
            end
        end

        assign bus.dir         = dir_q;
        assign bus.dir_changed = chg_q;
        assign bus.q_count     = cnt_q;
        assign bus.q_overflow  = ovf_q;
    end else begin : g_noq
        assign bus.dir         = DIR_RESET;
        assign bus.dir_changed = 1'b0;
        assign bus.q_count     = '0;
        assign bus.q_overflow  = 1'b0;
    end

endmodule

// File: tb/tb_wormy_input_conditioner.sv
// Directed bench for wormy_input_conditioner with DB_CYCLES=8, SYNC_STAGES=2, QDEPTH=2.
module tb_wormy_input_conditioner;
    import wormy_pkg::*;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [3:0] press_seen;
    logic       ovf_seen;
    logic       chg_seen;
    logic [1:0] dir_seen;
    logic [3:0] acc;

    wormy_input_conditioner_if #(.NUM_BTN(4), .QDEPTH(2)) bus ();

    wormy_input_conditioner #(
        .NUM_BTN     (4),
        .SYNC_STAGES (2),
        .DB_CYCLES   (8),
        .QDEPTH      (2),
        .DIR_MODE    (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.btn_raw = '0;
        bus.tick    = 1'b0;
        rst         = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        step(1);
        bus.tick = 1'b0;
    endtask

    // Hold mask until debounced, optionally ticking in the press cycle, then release.
    task automatic press_btn(input logic [3:0] m, input bit with_tick);
        bus.btn_raw = m;
        step(10);
        press_seen = bus.btn_press;
        if (with_tick) bus.tick = 1'b1;
        step(1);
        bus.tick    = 1'b0;
        ovf_seen    = bus.q_overflow;
        chg_seen    = bus.dir_changed;
        dir_seen    = bus.dir;
        bus.btn_raw = '0;
        step(11);
    endtask

    initial begin
        rst         = 1'b0;
        bus.tick    = 1'b0;
        bus.btn_raw = 4'b1010;

        // 1. reset with toggling buttons
        repeat (6) begin
            step(1);
            bus.btn_raw = ~bus.btn_raw;
        end
        check("rst_dir", 32'(bus.dir), 32'd1);
        check("rst_level", 32'(bus.btn_level), 32'd0);
        check("rst_qcount", 32'(bus.q_count), 32'd0);
        bus.btn_raw = '0;
        rst = 1'b1;
        acc = '0;
        repeat (12) begin
            step(1);
            acc |= bus.btn_press;
        end
        check("rst_no_press", 32'(acc), 32'd0);

        // 2. debounce: short glitch, then a held press
        bus.btn_raw = 4'b0001;
        step(5);
        bus.btn_raw = '0;
        acc = '0;
        repeat (15) begin
            step(1);
            acc |= bus.btn_level;
        end
        check("glitch_level", 32'(acc), 32'd0);
        bus.btn_raw = 4'b0001;
        step(9);
        check("db_level_at9", 32'(bus.btn_level), 32'd0);
        step(1);
        check("db_level_at10", 32'(bus.btn_level), 32'd1);
        check("db_press", 32'(bus.btn_press), 32'd1);
        step(1);
        check("db_press_single", 32'(bus.btn_press), 32'd0);
        step(9);
        bus.btn_raw = '0;
        step(11);
        check("db_release", 32'(bus.btn_level), 32'd0);

        // 3. reverse and duplicate rejection
        do_reset();
        press_btn(4'b1000, 1'b0);
        check("rev_left_q", 32'(bus.q_count), 32'd0);
        press_btn(4'b0010, 1'b0);
        check("dup_right_q", 32'(bus.q_count), 32'd0);
        press_btn(4'b0001, 1'b0);
        check("up_press", 32'(press_seen), 32'd1);
        check("up_q", 32'(bus.q_count), 32'd1);
        do_tick();
        check("tick_dir", 32'(bus.dir), 32'd0);
        check("tick_chg", 32'(bus.dir_changed), 32'd1);
        step(1);
        check("tick_chg_end", 32'(bus.dir_changed), 32'd0);
        check("tick_q", 32'(bus.q_count), 32'd0);
        do_tick();
        check("empty_tick_dir", 32'(bus.dir), 32'd0);
        check("empty_tick_chg", 32'(bus.dir_changed), 32'd0);

        // 4. queue depth and overflow
        do_reset();
        press_btn(4'b0001, 1'b0);
        press_btn(4'b1000, 1'b0);
        check("depth_q2", 32'(bus.q_count), 32'd2);
        check("depth_no_ovf", 32'(ovf_seen), 32'd0);
        press_btn(4'b0100, 1'b0);
        check("depth_ovf", 32'(ovf_seen), 32'd1);
        check("depth_q_full", 32'(bus.q_count), 32'd2);
        do_tick();
        check("depth_dir0", 32'(bus.dir), 32'd0);
        check("depth_q1", 32'(bus.q_count), 32'd1);
        do_tick();
        check("depth_dir3", 32'(bus.dir), 32'd3);
        check("depth_q0", 32'(bus.q_count), 32'd0);

        // 5. simultaneous presses, then push+pop on a full queue
        do_reset();
        press_btn(4'b0101, 1'b0);
        check("simul_press", 32'(press_seen), 32'd5);
        check("simul_q", 32'(bus.q_count), 32'd1);
        press_btn(4'b1000, 1'b0);
        check("simul_q2", 32'(bus.q_count), 32'd2);
        press_btn(4'b0001, 1'b1);
        check("pp_dir", 32'(dir_seen), 32'd0);
        check("pp_chg", 32'(chg_seen), 32'd1);
        check("pp_no_ovf", 32'(ovf_seen), 32'd0);
        check("pp_q", 32'(bus.q_count), 32'd2);
        do_tick();
        check("pp_dir_left", 32'(bus.dir), 32'd3);
        do_tick();
        check("pp_dir_up", 32'(bus.dir), 32'd0);
        check("pp_q0", 32'(bus.q_count), 32'd0);

        // 6. async reset between edges with a full queue
        do_reset();
        press_btn(4'b0001, 1'b0);
        press_btn(4'b1000, 1'b0);
        check("arst_pre_q", 32'(bus.q_count), 32'd2);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_dir", 32'(bus.dir), 32'd1);
        check("arst_q", 32'(bus.q_count), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
